// File: rtl/ifid_queue_pkg.sv
// Shared fetch/decode pipeline definitions.
//   PC_W_DEF / INST_W_DEF : default field widths of a fetched instruction
//   NOP_INST_DEF          : instruction value shown to decode when nothing is buffered
//   ifid_entry_t          : packed {pc, inst} pair, also carried into the ID/EX stage
package ifid_queue_pkg;

  localparam int unsigned PC_W_DEF   = 32;
  localparam int unsigned INST_W_DEF = 32;

  localparam logic [INST_W_DEF-1:0] NOP_INST_DEF = '0;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
  } ifid_entry_t;

endpackage

// File: rtl/ifid_queue_ctrl.sv
// Pointer/occupancy control for the IF/ID instruction buffer.
//   clk, rst_n        : clock, asynchronous active-low reset
//   push_req          : fetch offers an entry this cycle
//   hazard            : decode stalled, head must be held
//   flush             : discard every buffered entry
//   wr_en             : qualified push, entry[wr_ptr] is written this edge
//   rd_ptr, wr_ptr    : circular buffer pointers (wrap modulo DEPTH)
//   valid, full, count: registered occupancy status
module ifid_queue_ctrl #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_req,
  input  logic             hazard,
  input  logic             flush,
  output logic             wr_en,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr,
  output logic             valid,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic pop;

  assign valid = (count != '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A pop frees a slot in the same edge, so a full buffer still accepts a push.
  assign pop   = valid && !hazard && !flush;
  assign wr_en = push_req && !flush && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Emptying is done by catching the read side up; storage is left as is.
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/ifid_queue.sv
// DEPTH-entry IF/ID instruction buffer: fetch can run ahead while decode is
// stalled, a flush discards all buffered work, and decode sees the head entry
// or an all-zero/NOP bubble when empty. No same-cycle bypass.
//   clk_i, rst_i           : clock, asynchronous active-low reset
//   push_i, pc_i, inst_i   : fetch offer
//   full_o                 : DEPTH entries held, fetch must hold its PC
//   hazard_i, flush_i      : decode stall, branch/jump flush
//   valid_o, pc_o, inst_o  : head entry (bubble when not valid)
//   count_o                : occupied entries
module ifid_queue
  import ifid_queue_pkg::*;
#(
  parameter int unsigned        PC_W     = PC_W_DEF,
  parameter int unsigned        INST_W   = INST_W_DEF,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [INST_W-1:0]  NOP_INST = INST_W'(NOP_INST_DEF),
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              full_o,
  input  logic              hazard_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic [CNT_W-1:0]  count_o
);

  logic             wr_en;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  ifid_queue_ctrl #(
    .DEPTH(DEPTH)
  ) u_ctrl (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .push_req (push_i),
    .hazard   (hazard_i),
    .flush    (flush_i),
    .wr_en    (wr_en),
    .rd_ptr   (rd_ptr),
    .wr_ptr   (wr_ptr),
    .valid    (valid_o),
    .full     (full_o),
    .count    (count_o)
  );

  // Storage is not reset; count gates everything visible.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      pc_mem[wr_ptr]   <= pc_i;
      inst_mem[wr_ptr] <= inst_i;
    end
  end

  always_comb begin
    pc_o   = '0;
    inst_o = NOP_INST;
    if (valid_o) begin
      pc_o   = pc_mem[rd_ptr];
      inst_o = inst_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_ifid_queue.sv
module tb_ifid_queue;
  import ifid_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        push_i;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        full_o;
  logic        hazard_i;
  logic        flush_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [2:0]  count_o;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Reference model: the buffer contents in delivery order.
  ifid_entry_t exp_q[$];

  always #5 clk = ~clk;

  ifid_queue #(
    .PC_W     (32),
    .INST_W   (32),
    .DEPTH    (DEPTH),
    .NOP_INST (NOP)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .push_i   (push_i),
    .pc_i     (pc_i),
    .inst_i   (inst_i),
    .full_o   (full_o),
    .hazard_i (hazard_i),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .pc_o     (pc_o),
    .inst_o   (inst_o),
    .count_o  (count_o)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Model update from the rules: flush empties; otherwise the head leaves when
  // decode is not stalled, and an offer is taken if there is (or will be) room.
  always @(posedge clk) begin
    if (rst_i) begin
      if (flush_i) begin
        exp_q.delete();
      end else begin
        automatic bit do_pop  = (exp_q.size() != 0) && !hazard_i;
        automatic bit do_push = push_i && ((exp_q.size() < DEPTH) || do_pop);
        automatic ifid_entry_t e;
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) begin
          e.pc   = pc_i;
          e.inst = inst_i;
          exp_q.push_back(e);
        end
      end
    end
  end

  always @(negedge rst_i) exp_q.delete();

  // Monitor: every cycle compare the presented head against the model.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      check("valid", {63'b0, valid_o}, 64'd1);
      check("pc",    {32'b0, pc_o},    {32'b0, exp_q[0].pc});
      check("inst",  {32'b0, inst_o},  {32'b0, exp_q[0].inst});
    end else begin
      check("bubble_valid", {63'b0, valid_o}, 64'd0);
      check("bubble_pc",    {32'b0, pc_o},    64'd0);
      check("bubble_inst",  {32'b0, inst_o},  {32'b0, NOP});
    end
    check("count", {61'b0, count_o}, 64'(exp_q.size()));
    check("full",  {63'b0, full_o},  {63'b0, exp_q.size() == DEPTH});
  end

  task automatic cycle(input bit p, input logic [31:0] pc, input bit h, input bit f);
    push_i   = p;
    pc_i     = pc;
    inst_i   = $urandom;
    hazard_i = h;
    flush_i  = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic check_bubble_now(string tag);
    check({tag, "_valid"}, {63'b0, valid_o}, 64'd0);
    check({tag, "_pc"},    {32'b0, pc_o},    64'd0);
    check({tag, "_inst"},  {32'b0, inst_o},  {32'b0, NOP});
    check({tag, "_count"}, {61'b0, count_o}, 64'd0);
    check({tag, "_full"},  {63'b0, full_o},  64'd0);
  endtask

  initial begin
    logic [31:0] pc;
    rst_i    = 1'b1;
    push_i   = 1'b0;
    pc_i     = '0;
    inst_i   = '0;
    hazard_i = 1'b0;
    flush_i  = 1'b0;
    #1 rst_i = 1'b0;
    #1 check_bubble_now("reset");
    #15 rst_i = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back pushes with decode flowing.
    for (int unsigned k = 0; k < 3; k++) cycle(1'b1, 32'(4 * k), 1'b0, 1'b0);
    idle(3);

    // Stall decode while fetch runs ahead; the last two offers hit a full buffer.
    for (int unsigned k = 0; k < 6; k++) cycle(1'b1, 32'h10 + 32'(4 * k), 1'b1, 1'b0);
    idle(5);

    // Full buffer: pop and push in the same cycle.
    for (int unsigned k = 0; k < 4; k++) cycle(1'b1, 32'h40 + 32'(4 * k), 1'b1, 1'b0);
    cycle(1'b1, 32'h20, 1'b0, 1'b0);
    idle(6);

    // Flush with a concurrent push, then a normal push.
    for (int unsigned k = 0; k < 3; k++) cycle(1'b1, 32'h50 + 32'(4 * k), 1'b1, 1'b0);
    cycle(1'b1, 32'h60, 1'b0, 1'b1);
    cycle(1'b1, 32'h64, 1'b0, 1'b0);
    idle(2);

    // Random mix across many pointer wraps.
    pc = 32'h1000;
    for (int unsigned k = 0; k < 200; k++) begin
      cycle($urandom_range(0, 3) != 0, pc, $urandom_range(0, 2) == 0,
            $urandom_range(0, 31) == 0);
      pc += 32'h4;
    end
    idle(6);

    // Asynchronous reset with three entries held.
    for (int unsigned k = 0; k < 3; k++) cycle(1'b1, 32'h70 + 32'(4 * k), 1'b1, 1'b0);
    push_i   = 1'b0;
    hazard_i = 1'b0;
    #1 check({61'b0, count_o}, 64'd3, 64'd3);
    #1 rst_i = 1'b0;
    #1 check_bubble_now("async_reset");
    #3 rst_i = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 32'h80, 1'b0, 1'b0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifid_queue.md
Name: ifid_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- A DEPTH-entry instruction buffer between fetch and decode that holds {pc, inst} pairs.
- Lets fetch run ahead while decode is stalled by a hazard, and discards all buffered work on a branch/jump flush.
- Presents the head entry to decode, or an all-zero bubble when the buffer is empty.

Parameters:
- PC_W, 32, width of the program counter field.
- INST_W, 32, width of the instruction field.
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- NOP_INST, 32'b0, instruction value presented on inst_o when the buffer is empty.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  reset, asynchronous and active-low.
- push_i  input  1  fetch offers {pc_i, inst_i} this cycle.
- pc_i  input  PC_W  PC of the offered instruction.
- inst_i  input  INST_W  offered instruction.
- full_o  output  1  buffer holds DEPTH entries.
- hazard_i  input  1  decode stalled; head entry must be held.
- flush_i  input  1  discard all entries, including the head.
- valid_o  output  1  pc_o/inst_o carry a real instruction.
- pc_o  output  PC_W  head PC, or 0 when empty.
- inst_o  output  INST_W  head instruction, or NOP_INST when empty.
- count_o  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset:
  - rst_i low immediately clears rd_ptr, wr_ptr and count, independent of clk_i.
  - While and after reset: valid_o=0, pc_o=0, inst_o=NOP_INST, full_o=0, count_o=0.
  - Entry storage need not be cleared.
  - A reset asserted mid-operation drops every entry; no partial state survives.
- Storage and pointers:
  - Circular buffer of registers.
  - rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count tracks occupancy in the range 0..DEPTH.
- Outputs:
  - Combinational from registered state only; no input-to-output combinational path.
  - valid_o = (count != 0).
  - pc_o/inst_o = entry[rd_ptr] when valid_o, else the bubble values.
  - full_o = (count == DEPTH).
- Pop: pop = valid_o && !hazard_i && !flush_i. On pop, rd_ptr advances at the clock edge.
- Push: push = push_i && !flush_i && (!full_o || pop).
  - On push, entry[wr_ptr] <= {pc_i, inst_i} and wr_ptr advances.
  - Push while full with no pop: the offer is ignored and state is unchanged; fetch must hold its PC while full_o=1.
  - Push while full with a pop in the same cycle: accepted; count stays at DEPTH.
- Count update: count <= count + push - pop.
- Latency:
  - A push into an empty buffer is visible on pc_o/inst_o with valid_o=1 in the cycle after the edge.
  - There is no same-cycle bypass, matching the one-cycle IF/ID register timing.
- Hazard:
  - hazard_i=1 freezes the head; outputs stay stable every cycle it is held.
  - Pushes continue until full.
  - hazard_i while empty has no effect beyond blocking a pop that could not occur anyway.
- Flush:
  - Highest priority after reset; overrides push, pop and hazard.
  - On the edge with flush_i=1: count <= 0, rd_ptr <= wr_ptr.
  - The next cycle shows the bubble.
  - The cycle after a flush accepts pushes normally.
- Simultaneous push and pop when count=1: the head advances to the new entry, and count stays 1.
- Simultaneous push and pop when count=0 is impossible, because pop requires valid_o.

Decomposition:
- Shared pipeline package:
  - NOP_INST default.
  - Default PC_W/INST_W.
  - Packed ifid_entry_t typedef {pc, inst} reused by the ID/EX stage.
- One natural sub-module, ifid_queue_ctrl: owns the pointers, count, push/pop/flush qualification and full/valid generation.
- The top level holds the entry array and the head mux.

Test Plan:
- Reset, then push 3 entries (pc 0x0/0x4/0x8) with hazard_i=0 -> outputs show pc 0x0, 0x4, 0x8 on consecutive cycles starting one cycle after the first push; count_o peaks at 1.
- hazard_i=1 for 6 cycles while fetch pushes pc 0x10,0x14,... -> pc_o held at 0x10; full_o=1 after 4 pushes; 5th/6th offers ignored; on release, drain order is 0x10,0x14,0x18,0x1C.
- Full buffer, hazard_i=0, push_i=1 of pc 0x20 -> pop and push in the same cycle; count_o stays 4; 0x20 appears last in the drain.
- Buffer holding 3 entries, flush_i=1 with push_i=1 -> next cycle valid_o=0, pc_o=0, inst_o=NOP_INST, count_o=0; the pushed entry is discarded; a push on the following cycle appears after one cycle.
- Wrap-around: run 3*DEPTH+1 mixed push/pop cycles with random hazard -> scoreboard shows in-order, loss-free delivery across pointer wrap.
- Assert rst_i low mid-cycle with count_o=3 -> outputs go to bubble and count_o=0 without waiting for a clk_i edge; after release, the first push behaves as from a cold start.
